// File: rtl/md_pkg.sv
// Shared types and defaults for the mult_div issue controller.
// Op encoding, controller states and the registered mult_div control bundle.
package md_pkg;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ONE     = 2'd1,
        ST_DIV_RUN = 2'd2
    } md_state_e;

    typedef struct packed {
        logic en;
        logic is_mult;
        logic is_multu;
        logic is_div;
        logic is_divu;
        logic hi_wen;
        logic lo_wen;
    } md_ctl_t;

    localparam int MD_MAX_DIV_CYCLES = 64;
    localparam int MD_CNT_W          = 7;

    // Unknown op codes decode to an all-zero bundle, i.e. nothing is issued.
    function automatic md_ctl_t md_decode(input logic [2:0] op);
        md_ctl_t c;
        c = '0;
        case (md_op_e'(op))
            OP_MULT:  begin c.en = 1'b1; c.is_mult  = 1'b1; end
            OP_MULTU: begin c.en = 1'b1; c.is_multu = 1'b1; end
            OP_DIV:   begin c.en = 1'b1; c.is_div   = 1'b1; end
            OP_DIVU:  begin c.en = 1'b1; c.is_divu  = 1'b1; end
            OP_MTHI:  begin c.en = 1'b1; c.hi_wen   = 1'b1; end
            OP_MTLO:  begin c.en = 1'b1; c.lo_wen   = 1'b1; end
            default:  c = '0;
        endcase
        return c;
    endfunction

    function automatic logic md_is_div_op(input md_ctl_t c);
        return c.is_div | c.is_divu;
    endfunction

endpackage

// File: rtl/md_div_watchdog.sv
// Divide-run cycle counter with a sticky timeout flag.
// Fires when the run reaches MAX_DIV_CYCLES cycles without a completion.
module md_div_watchdog
    import md_pkg::*;
#(
    parameter int MAX_DIV_CYCLES = MD_MAX_DIV_CYCLES,
    parameter int CNT_W          = MD_CNT_W
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    input  logic clear,
    input  logic complete,
    output logic expire,
    output logic timeout
);

    logic [CNT_W-1:0] count_r;
    logic             timeout_r;

    assign expire  = run & ~complete & (count_r == CNT_W'(MAX_DIV_CYCLES - 1));
    assign timeout = timeout_r;

    // Counter advances each divide cycle; the flag latches until reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_r   <= '0;
            timeout_r <= 1'b0;
        end else begin
            if (clear) begin
                count_r <= '0;
            end else if (run) begin
                count_r <= count_r + CNT_W'(1);
            end else begin
                count_r <= count_r;
            end
            timeout_r <= timeout_r | expire;
        end
    end

endmodule

// File: rtl/md_issue_ctrl.sv
// Sequencer that issues EX-stage HI/LO ops to mult_div from registered controls,
// holding operands for a whole divide and stalling HI/LO reads while busy.
module md_issue_ctrl
    import md_pkg::*;
#(
    parameter int MAX_DIV_CYCLES = MD_MAX_DIV_CYCLES,
    parameter int CNT_W          = MD_CNT_W
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_rs,
    input  logic [31:0] req_rt,
    input  logic        flush,
    input  logic        hilo_read,
    output logic        hilo_stall,
    output logic        busy,
    output logic        div_timeout,
    output logic        md_en,
    output logic        md_is_mult,
    output logic        md_is_multu,
    output logic        md_is_div,
    output logic        md_is_divu,
    output logic        md_hi_wen,
    output logic        md_lo_wen,
    output logic [31:0] md_rs_data,
    output logic [31:0] md_rt_data,
    input  logic        md_complete
);

    md_state_e   state_r, state_s;
    md_ctl_t     ctl_r, ctl_s;
    md_ctl_t     dec_s;
    logic [31:0] rs_r, rs_s;
    logic [31:0] rt_r, rt_s;
    logic        busy_r;
    logic        accept_s;
    logic        wd_run_s;
    logic        wd_clear_s;
    logic        wd_expire_s;

    assign req_ready  = (state_r == ST_IDLE) | (state_r == ST_ONE);
    assign hilo_stall = hilo_read & busy_r;
    assign busy       = busy_r;
    assign wd_run_s   = (state_r == ST_DIV_RUN);
    assign wd_clear_s = wd_run_s & (state_s != ST_DIV_RUN);

    assign md_en       = ctl_r.en;
    assign md_is_mult  = ctl_r.is_mult;
    assign md_is_multu = ctl_r.is_multu;
    assign md_is_div   = ctl_r.is_div;
    assign md_is_divu  = ctl_r.is_divu;
    assign md_hi_wen   = ctl_r.hi_wen;
    assign md_lo_wen   = ctl_r.lo_wen;
    assign md_rs_data  = rs_r;
    assign md_rt_data  = rt_r;

    // Next state, next control bundle and operand capture.
    always_comb begin
        accept_s = req_valid & req_ready & ~flush;
        dec_s    = md_decode(req_op);
        state_s  = state_r;
        ctl_s    = ctl_r;
        rs_s     = rs_r;
        rt_s     = rt_r;
        case (state_r)
            ST_IDLE, ST_ONE: begin
                if (accept_s && dec_s.en) begin
                    ctl_s = dec_s;
                    rs_s  = req_rs;
                    rt_s  = req_rt;
                    if (md_is_div_op(dec_s)) begin
                        state_s = ST_DIV_RUN;
                    end else begin
                        state_s = ST_ONE;
                    end
                end else begin
                    state_s = ST_IDLE;
                    ctl_s   = '0;
                end
            end
            // Flush is deliberately not looked at here: the divide is committed.
            ST_DIV_RUN: begin
                if (md_complete || wd_expire_s) begin
                    state_s = ST_IDLE;
                    ctl_s   = '0;
                end else begin
                    state_s = ST_DIV_RUN;
                end
            end
            default: begin
                state_s = ST_IDLE;
                ctl_s   = '0;
            end
        endcase
    end

    // State, control and operand registers; busy is registered alongside state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
            ctl_r   <= '0;
            rs_r    <= 32'd0;
            rt_r    <= 32'd0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            ctl_r   <= ctl_s;
            rs_r    <= rs_s;
            rt_r    <= rt_s;
            busy_r  <= (state_s != ST_IDLE);
        end
    end

    md_div_watchdog #(
        .MAX_DIV_CYCLES (MAX_DIV_CYCLES),
        .CNT_W          (CNT_W)
    ) u_watchdog (
        .clk      (clk),
        .reset    (reset),
        .run      (wd_run_s),
        .clear    (wd_clear_s),
        .complete (md_complete),
        .expire   (wd_expire_s),
        .timeout  (div_timeout)
    );

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Bench for md_issue_ctrl: directed scenarios plus randomized op streams checked
// against an arithmetic HI/LO model and a per-op table of expected mult_div controls.
module tb_md_issue_ctrl;
    import md_pkg::*;

    localparam int MAXC = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, flush, hilo_read, hilo_stall, busy, div_timeout;
    logic [2:0]  req_op;
    logic [31:0] req_rs, req_rt, md_rs_data, md_rt_data;
    logic        md_en, md_is_mult, md_is_multu, md_is_div, md_is_divu, md_hi_wen, md_lo_wen;
    logic        md_complete;
    logic [6:0]  md_vec;
    logic [31:0] hi_q, lo_q;
    logic [31:0] exp_hi, exp_lo;
    int          n_checks = 0;
    int          n_pass   = 0;

    always #5 clk = ~clk;

    assign md_vec = {md_en, md_is_mult, md_is_multu, md_is_div, md_is_divu, md_hi_wen, md_lo_wen};

    md_issue_ctrl #(.MAX_DIV_CYCLES(MAXC), .CNT_W(7)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_rs(req_rs), .req_rt(req_rt), .flush(flush),
        .hilo_read(hilo_read), .hilo_stall(hilo_stall), .busy(busy),
        .div_timeout(div_timeout), .md_en(md_en), .md_is_mult(md_is_mult),
        .md_is_multu(md_is_multu), .md_is_div(md_is_div), .md_is_divu(md_is_divu),
        .md_hi_wen(md_hi_wen), .md_lo_wen(md_lo_wen), .md_rs_data(md_rs_data),
        .md_rt_data(md_rt_data), .md_complete(md_complete)
    );

    // Stand-in for the mult_div HI/LO unit.
    initial begin hi_q = 32'd0; lo_q = 32'd0; end
    always @(posedge clk) begin
        if (md_en) begin
            if (md_is_mult)  {hi_q, lo_q} <= 64'($signed(md_rs_data)) * 64'($signed(md_rt_data));
            if (md_is_multu) {hi_q, lo_q} <= {32'd0, md_rs_data} * {32'd0, md_rt_data};
            if (md_hi_wen)   hi_q <= md_rs_data;
            if (md_lo_wen)   lo_q <= md_rs_data;
            if (md_is_div && md_complete) begin
                lo_q <= $signed(md_rs_data) / $signed(md_rt_data);
                hi_q <= $signed(md_rs_data) % $signed(md_rt_data);
            end
            if (md_is_divu && md_complete) begin
                lo_q <= md_rs_data / md_rt_data;
                hi_q <= md_rs_data % md_rt_data;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [6:0] ctl_for(input int op);
        case (op)
            0:       return 7'b1100000;
            1:       return 7'b1010000;
            2:       return 7'b1001000;
            3:       return 7'b1000100;
            4:       return 7'b1000010;
            5:       return 7'b1000001;
            default: return 7'b0000000;
        endcase
    endfunction

    // Architectural HI/LO effect of one op, from plain integer arithmetic.
    task automatic model_apply(input int op, input logic [31:0] rs, input logic [31:0] rt);
        longint          sp;
        longint unsigned up;
        int              a, b;
        a = rs;
        b = rt;
        case (op)
            0: begin sp = longint'(a) * longint'(b); exp_hi = sp[63:32]; exp_lo = sp[31:0]; end
            1: begin up = longint'({32'd0, rs}) * longint'({32'd0, rt}); exp_hi = up[63:32]; exp_lo = up[31:0]; end
            2: begin exp_lo = a / b; exp_hi = a % b; end
            3: begin exp_lo = rs / rt; exp_hi = rs % rt; end
            4: exp_hi = rs;
            5: exp_lo = rs;
            default: ;
        endcase
    endtask

    task automatic present(input int op, input logic [31:0] rs, input logic [31:0] rt, input logic fl);
        req_valid = 1'b1;
        req_op    = 3'(op);
        req_rs    = rs;
        req_rt    = rt;
        flush     = fl;
    endtask

    task automatic idle_inputs();
        req_valid = 1'b0;
        flush     = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        n_checks++;
        if ({busy, md_vec, div_timeout, md_rs_data, md_rt_data} !== 73'd0) $display("FAIL reset_in: busy/md/to/rs/rt=%h required 0", {busy, md_vec, div_timeout, md_rs_data, md_rt_data});
        else n_pass++;
        tick();
        reset = 1'b1;
        tick();
        n_checks++;
        if ({req_ready, busy, md_vec, div_timeout} !== 10'b1000000000) $display("FAIL reset_out: ready/busy/md/to=%b required 1000000000", {req_ready, busy, md_vec, div_timeout});
        else n_pass++;
    endtask

    task automatic test_mult();
        present(0, 32'hFFFFFFFE, 32'd3, 1'b0);
        model_apply(0, 32'hFFFFFFFE, 32'd3);
        tick();
        idle_inputs();
        n_checks++;
        if ({md_vec, busy, md_rs_data, md_rt_data} !== {7'b1100000, 1'b1, 32'hFFFFFFFE, 32'd3}) $display("FAIL mult_issue: md=%b busy=%b rs=%h rt=%h required 1100000 1 fffffffe 3", md_vec, busy, md_rs_data, md_rt_data);
        else n_pass++;
        tick();
        n_checks++;
        if ({md_vec, busy} !== 8'd0) $display("FAIL mult_drop: md=%b busy=%b required 0", md_vec, busy);
        else n_pass++;
        n_checks++;
        if ({hi_q, lo_q} !== {32'hFFFFFFFF, 32'hFFFFFFFA} || {exp_hi, exp_lo} !== {hi_q, lo_q}) $display("FAIL mult_hilo: hi=%h lo=%h required ffffffff fffffffa", hi_q, lo_q);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        present(4, 32'h1234, 32'd0, 1'b0);
        tick();
        n_checks++;
        if ({md_vec, req_ready, md_rs_data} !== {7'b1000010, 1'b1, 32'h1234}) $display("FAIL b2b_mthi: md=%b ready=%b rs=%h required 1000010 1 1234", md_vec, req_ready, md_rs_data);
        else n_pass++;
        present(5, 32'h5678, 32'd0, 1'b0);
        tick();
        idle_inputs();
        n_checks++;
        if ({md_vec, busy, md_rs_data} !== {7'b1000001, 1'b1, 32'h5678}) $display("FAIL b2b_mtlo: md=%b busy=%b rs=%h required 1000001 1 5678", md_vec, busy, md_rs_data);
        else n_pass++;
        model_apply(4, 32'h1234, 32'd0);
        model_apply(5, 32'h5678, 32'd0);
        tick();
        n_checks++;
        if ({busy, hi_q, lo_q} !== {1'b0, 32'h1234, 32'h5678}) $display("FAIL b2b_hilo: busy=%b hi=%h lo=%h required 0 1234 5678", busy, hi_q, lo_q);
        else n_pass++;
    endtask

    task automatic test_divu_stall();
        int errs;
        errs = 0;
        hilo_read = 1'b1;
        present(3, 32'd100, 32'd7, 1'b0);
        tick();
        idle_inputs();
        for (int k = 0; k <= 4; k++) begin
            if ({req_ready, hilo_stall, busy, md_vec, md_rs_data} !== {3'b011, 7'b1000100, 32'd100}) errs++;
            md_complete = (k == 4);
            tick();
        end
        md_complete = 1'b0;
        n_checks++;
        if (errs != 0) $display("FAIL divu_run: %0d bad DIV_RUN cycles required 0", errs);
        else n_pass++;
        n_checks++;
        if ({busy, hilo_stall, req_ready, md_vec, hi_q, lo_q} !== {3'b001, 7'd0, 32'd2, 32'd14}) $display("FAIL divu_done: busy=%b stall=%b md=%b hi=%0d lo=%0d required 0 0 0 2 14", busy, hilo_stall, md_vec, hi_q, lo_q);
        else n_pass++;
        hilo_read = 1'b0;
        model_apply(3, 32'd100, 32'd7);
    endtask

    task automatic test_flush();
        present(2, 32'hFFFFFFEC, 32'd3, 1'b1);
        tick();
        idle_inputs();
        n_checks++;
        if ({busy, md_vec} !== 8'd0) $display("FAIL flush_accept: busy=%b md=%b required 0", busy, md_vec);
        else n_pass++;
        present(2, 32'hFFFFFFEC, 32'd3, 1'b0);
        tick();
        idle_inputs();
        for (int k = 0; k <= 3; k++) begin
            flush       = (k == 1);
            md_complete = (k == 3);
            tick();
        end
        md_complete = 1'b0;
        flush = 1'b0;
        model_apply(2, 32'hFFFFFFEC, 32'd3);
        n_checks++;
        if ({busy, hi_q, lo_q} !== {1'b0, 32'hFFFFFFFE, 32'hFFFFFFFA}) $display("FAIL flush_mid_div: busy=%b hi=%h lo=%h required 0 fffffffe fffffffa", busy, hi_q, lo_q);
        else n_pass++;
    endtask

    task automatic test_random();
        int          op, lat, errs;
        logic [31:0] rs, rt;
        logic        fl, acc;
        errs = 0;
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                idle_inputs();
                tick();
                if ({md_vec, busy} !== 8'd0) errs++;
            end else begin
                op = $urandom_range(0, 7);
                rs = $urandom;
                rt = $urandom;
                if (rt == 32'd0 || rt == 32'hFFFFFFFF) rt = 32'd5;
                fl  = ($urandom_range(0, 4) == 0);
                acc = !fl && op <= 5;
                if (req_ready !== 1'b1) errs++;
                present(op, rs, rt, fl);
                if (acc) model_apply(op, rs, rt);
                tick();
                idle_inputs();
                if (acc) begin
                    if ({md_vec, busy, md_rs_data, md_rt_data} !== {ctl_for(op), 1'b1, rs, rt}) errs++;
                end else begin
                    if ({md_vec, busy} !== 8'd0) errs++;
                end
                if (acc && (op == 2 || op == 3)) begin
                    lat = $urandom_range(0, MAXC - 1);
                    for (int k = 0; k <= lat; k++) begin
                        if ({req_ready, busy, md_vec, md_rs_data, md_rt_data} !== {2'b01, ctl_for(op), rs, rt}) errs++;
                        md_complete = (k == lat);
                        tick();
                    end
                    md_complete = 1'b0;
                    if ({busy, hi_q, lo_q} !== {1'b0, exp_hi, exp_lo}) errs++;
                end
            end
        end
        tick();
        n_checks++;
        if (errs != 0) $display("FAIL random_cycles: %0d bad cycles required 0", errs);
        else n_pass++;
        n_checks++;
        if ({hi_q, lo_q} !== {exp_hi, exp_lo}) $display("FAIL random_hilo: hi=%h lo=%h required %h %h", hi_q, lo_q, exp_hi, exp_lo);
        else n_pass++;
    endtask

    task automatic test_timeout();
        int cnt;
        cnt = 0;
        md_complete = 1'b0;
        present(3, 32'd50, 32'd9, 1'b0);
        tick();
        idle_inputs();
        while (busy && cnt < 40) begin
            cnt++;
            tick();
        end
        n_checks++;
        if (cnt != MAXC) $display("FAIL timeout_len: DIV_RUN cycles=%0d required %0d", cnt, MAXC);
        else n_pass++;
        n_checks++;
        if ({busy, md_vec, div_timeout, req_ready} !== 10'b0000000011) $display("FAIL timeout_flag: busy/md/to/ready=%b required 0000000011", {busy, md_vec, div_timeout, req_ready});
        else n_pass++;
        present(1, 32'd6, 32'd7, 1'b0);
        tick();
        idle_inputs();
        tick();
        n_checks++;
        if (div_timeout !== 1'b1) $display("FAIL timeout_sticky: div_timeout=%b required 1", div_timeout);
        else n_pass++;
        present(3, 32'd80, 32'd3, 1'b0);
        tick();
        idle_inputs();
        tick();
        #2 reset = 1'b0;
        #1;
        n_checks++;
        if ({busy, md_vec, div_timeout, md_rs_data} !== 41'd0) $display("FAIL async_reset: busy/md/to/rs=%h required 0", {busy, md_vec, div_timeout, md_rs_data});
        else n_pass++;
        #3 reset = 1'b1;
        tick();
        n_checks++;
        if ({req_ready, busy, div_timeout} !== 3'b100) $display("FAIL reset_clears: ready/busy/to=%b required 100", {req_ready, busy, div_timeout});
        else n_pass++;
    endtask

    initial begin
        reset       = 1'b0;
        req_valid   = 1'b0;
        req_op      = 3'd0;
        req_rs      = 32'd0;
        req_rt      = 32'd0;
        flush       = 1'b0;
        hilo_read   = 1'b0;
        md_complete = 1'b0;
        exp_hi      = 32'd0;
        exp_lo      = 32'd0;
        test_reset();
        test_mult();
        test_back_to_back();
        test_divu_stall();
        test_flush();
        test_random();
        test_timeout();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/md_issue_ctrl.md
Name: md_issue_ctrl

Overview:
- Sequencer between the EX stage and the mult_div HI/LO unit.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO requests over a valid/ready handshake and latches the operands.
- Drives mult_div's enable, op-select and operand ports from registers, so operands stay stable for a whole iterative divide.
- Stalls MFHI/MFLO while an op is in flight; a watchdog flags a divide that never completes.

Parameters:
- MAX_DIV_CYCLES, 64, divide-run cycles before timeout abort (must be >= divider worst case + 2).
- CNT_W, 7, width of the div cycle counter; must hold MAX_DIV_CYCLES.

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-low reset
- req_valid  input  1  EX presents an op
- req_ready  output  1  controller can accept
- req_op  input  3  op code (package enum)
- req_rs  input  32  rs operand
- req_rt  input  32  rt operand
- flush  input  1  pipeline flush; cancels the offered request only
- hilo_read  input  1  EX holds MFHI/MFLO
- hilo_stall  output  1  stall request to the pipeline
- busy  output  1  an op is in flight
- div_timeout  output  1  sticky watchdog flag
- md_en, md_is_mult, md_is_multu, md_is_div, md_is_divu, md_hi_wen, md_lo_wen  output  1 each  mult_div controls
- md_rs_data  output  32  held rs operand
- md_rt_data  output  32  held rt operand
- md_complete  input  1  mult_div complete

Behaviour:
- Reset: state IDLE, counter 0, operand regs 0, all md_* 0, busy 0, div_timeout 0. req_ready=1 once reset is released.
- reset is asserted asynchronously mid-op: same values; the in-flight op is discarded and HI/LO contents are undefined.
- States: IDLE, ONE (single-cycle op issued), DIV_RUN.
- Accept: fires when req_valid & req_ready & ~flush. A flush in the accept cycle means no accept and no state change.
- Op codes outside the enum: treated as no-op; accepted, nothing issued.
- req_ready = (state==IDLE) | (state==ONE). It is 0 in DIV_RUN.
- Accept of MULT/MULTU/MTHI/MTLO:
  - Next cycle state=ONE, md_en=1, exactly one md_is_*/md_*_wen set, operands registered.
  - HI/LO update at the end of that ONE cycle.
  - Back-to-back accepts in ONE keep state ONE, giving 1 op/cycle.
  - No accept in ONE: go to IDLE, clear md_en and selects.
- Accept of DIV/DIVU:
  - Next cycle state=DIV_RUN, md_en=1, md_is_div or md_is_divu set, operands held constant.
  - Counter increments each DIV_RUN cycle.
- md_complete=1 sampled in DIV_RUN: final quotient/remainder written that edge by mult_div; next cycle IDLE, md_en=0, counter cleared.
- Divide-by-zero: no special handling; completes with whatever mult_div produces.
- Timeout: counter reaches MAX_DIV_CYCLES-1 without complete → next cycle IDLE, md_en=0, div_timeout=1 until reset.
- flush during ONE or DIV_RUN: ignored; the op is already committed.
- busy = (state != IDLE).
- hilo_stall = hilo_read & busy. A read in the cycle after ONE/DIV_RUN returns to IDLE sees updated HI/LO.
- md_complete outside DIV_RUN: ignored.
- All md_* outputs come from flops, with no combinational path from req_* to md_*.
- req_ready and hilo_stall are combinational from state and inputs.

Decomposition:
- Package md_pkg holds:
  - op enum: OP_MULT=0, OP_MULTU=1, OP_DIV=2, OP_DIVU=3, OP_MTHI=4, OP_MTLO=5.
  - state enum.
  - default MAX_DIV_CYCLES constant.
- One sub-module: md_div_watchdog (counter, compare, sticky flag), cleared by the controller on exit from DIV_RUN.

Test Plan:
- Reset released, req_valid=0 → req_ready=1, busy=0, all md_* 0, div_timeout=0.
- MULT rs=0xFFFFFFFE, rt=3 accepted at cycle N → md_en=1 and md_is_mult=1 at N+1 only. mult_div HI=0xFFFFFFFF, LO=0xFFFFFFFA at N+2.
- MTHI 0x1234 then MTLO 0x5678 on consecutive cycles → both accepted (req_ready stays 1), two ONE cycles, HI=0x1234, LO=0x5678.
- DIVU 100/7, with hilo_read held from acceptance:
  - req_ready=0 and hilo_stall=1 for every DIV_RUN cycle.
  - md_rs_data=100 held constant.
  - After complete, next cycle IDLE; LO=14, HI=2; hilo_stall drops.
- req_valid=1 with flush=1 (DIV) → not accepted, state stays IDLE. flush pulsed mid-DIV_RUN → divide still completes.
- Stubbed md_complete tied 0, MAX_DIV_CYCLES=8 → DIV_RUN exactly 8 cycles, then IDLE with div_timeout=1. It stays 1 across further ops and clears only on reset.
